// File: rtl/rc5_key_expand.sv
// RC5-32/12/16 key schedule: expands a 128-bit user key into the 26-word S table,
// performing one init write or one mixing step per clock.
module rc5_key_expand #(
    parameter int unsigned T_WORDS = 26,
    parameter int unsigned C_WORDS = 4,
    parameter logic [31:0] P_W     = 32'hB7E15163,
    parameter logic [31:0] Q_W     = 32'h9E3779B9
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [32*C_WORDS-1:0]  key_in,
    input  logic                   key_vld,
    output logic                   busy,
    output logic                   key_rdy,
    output logic [32*T_WORDS-1:0]  skey_out
);

    localparam int unsigned IW = $clog2(T_WORDS);
    localparam int unsigned JW = (C_WORDS > 1) ? $clog2(C_WORDS) : 1;
    localparam int unsigned KW = $clog2(3 * T_WORDS);

    localparam logic [IW-1:0] I_LAST = IW'(T_WORDS - 1);
    localparam logic [JW-1:0] J_LAST = JW'(C_WORDS - 1);
    localparam logic [KW-1:0] K_LAST = KW'(3 * T_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        MIX,
        DONE
    } state_t;

    state_t state, stateNext;

    logic [31:0]   sWords [T_WORDS];
    logic [31:0]   lWords [C_WORDS];
    logic [IW-1:0] iCnt;
    logic [JW-1:0] jCnt;
    logic [KW-1:0] kCnt;
    logic [31:0]   aReg, bReg;
    logic [31:0]   initVal;

    logic [31:0]   aNext, bNext;
    logic [4:0]    rotAmt;
    logic          accept;

    // Rotate by zero is special-cased so no shift-by-32 term ever appears.
    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        return (n == 5'd0) ? x : ((x << n) | (x >> (6'd32 - {1'b0, n})));
    endfunction

    assign accept  = ((state == IDLE) || (state == DONE)) && key_vld;
    assign busy    = (state == INIT) || (state == MIX);
    assign key_rdy = (state == DONE);

    always_comb begin
        aNext  = rotl(sWords[iCnt] + aReg + bReg, 5'd3);
        rotAmt = 5'(aNext + bReg);
        bNext  = rotl(lWords[jCnt] + aNext + bReg, rotAmt);
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE, DONE: if (key_vld) stateNext = INIT;
            INIT:       if (iCnt == I_LAST) stateNext = MIX;
            MIX:        if (kCnt == K_LAST) stateNext = DONE;
            default:    stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= stateNext;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int unsigned n = 0; n < T_WORDS; n++) sWords[n] <= '0;
            for (int unsigned n = 0; n < C_WORDS; n++) lWords[n] <= '0;
            iCnt    <= '0;
            jCnt    <= '0;
            kCnt    <= '0;
            aReg    <= '0;
            bReg    <= '0;
            initVal <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        // Byte K[b] sits at key_in[127-8b]; L words are little-endian.
                        for (int unsigned w = 0; w < C_WORDS; w++)
                            for (int unsigned q = 0; q < 4; q++)
                                lWords[w][8*q +: 8] <= key_in[32*C_WORDS-1-8*(4*w+q) -: 8];
                        iCnt    <= '0;
                        aReg    <= '0;
                        bReg    <= '0;
                        initVal <= P_W;
                    end
                end
                INIT: begin
                    sWords[iCnt] <= initVal;
                    initVal      <= initVal + Q_W;
                    if (iCnt == I_LAST) begin
                        iCnt <= '0;
                        jCnt <= '0;
                        kCnt <= '0;
                    end else begin
                        iCnt <= iCnt + 1'b1;
                    end
                end
                MIX: begin
                    sWords[iCnt] <= aNext;
                    lWords[jCnt] <= bNext;
                    aReg         <= aNext;
                    bReg         <= bNext;
                    iCnt         <= (iCnt == I_LAST) ? '0 : iCnt + 1'b1;
                    jCnt         <= (jCnt == J_LAST) ? '0 : jCnt + 1'b1;
                    kCnt         <= kCnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < T_WORDS; g++) begin : g_skey
        assign skey_out[32*g +: 32] = sWords[g];
    end

endmodule

// File: tb/tb_rc5_key_expand.sv
// Bench for rc5_key_expand: reference key-schedule model feeding a scoreboard,
// cycle-exact latency checks, and a known-answer RC5 encryption.
module tb_rc5_key_expand;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_vld = 1'b0;
    logic         busy;
    logic         key_rdy;
    logic [831:0] skey_out;

    int checks = 0;
    int errors = 0;
    logic [831:0] sb[$];

    rc5_key_expand #(
        .T_WORDS(26),
        .C_WORDS(4),
        .P_W(32'hB7E15163),
        .Q_W(32'h9E3779B9)
    ) dut (
        .clk(clk),
        .clr(clr),
        .key_in(key_in),
        .key_vld(key_vld),
        .busy(busy),
        .key_rdy(key_rdy),
        .skey_out(skey_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        int m;
        m = n & 31;
        if (m == 0) return x;
        return (x << m) | (x >> (32 - m));
    endfunction

    function automatic logic [831:0] model(input logic [127:0] key, output int rot0);
        logic [7:0]  kb [16];
        logic [31:0] l  [4];
        logic [31:0] s  [26];
        logic [31:0] a, b, t;
        logic [831:0] res;
        int i, j;
        rot0 = 0;
        for (int n = 0; n < 16; n++) kb[n] = key[127-8*n -: 8];
        for (int n = 0; n < 4; n++) l[n] = {kb[4*n+3], kb[4*n+2], kb[4*n+1], kb[4*n]};
        s[0] = 32'hB7E15163;
        for (int n = 1; n < 26; n++) s[n] = s[n-1] + 32'h9E3779B9;
        a = 0; b = 0; i = 0; j = 0;
        for (int it = 0; it < 78; it++) begin
            a = rol(s[i] + a + b, 3);
            s[i] = a;
            t = a + b;
            if (t[4:0] == 5'd0) rot0++;
            b = rol(l[j] + a + b, int'(t[4:0]));
            l[j] = b;
            i = (i + 1) % 26;
            j = (j + 1) % 4;
        end
        for (int n = 0; n < 26; n++) res[32*n +: 32] = s[n];
        return res;
    endfunction

    function automatic logic [63:0] encrypt(input logic [831:0] tab);
        logic [31:0] a, b;
        a = tab[31:0];
        b = tab[63:32];
        for (int r = 1; r <= 12; r++) begin
            a = rol(a ^ b, int'(b[4:0])) + tab[32*(2*r) +: 32];
            b = rol(b ^ a, int'(a[4:0])) + tab[32*(2*r+1) +: 32];
        end
        return {a, b};
    endfunction

    task automatic accept_key(input logic [127:0] k);
        int r;
        key_in  = k;
        key_vld = 1'b1;
        @(posedge clk); #1;
        key_vld = 1'b0;
        sb.push_back(model(k, r));
    endtask

    // Called at #1 after the accepting edge plus 'elapsed' further edges.
    task automatic wait_done(input int elapsed, input string name);
        logic [831:0] exp;
        repeat (103 - elapsed) @(posedge clk);
        #1;
        checks++;
        if (key_rdy !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_edge103 key_rdy=%b busy=%b required key_rdy=0 busy=1", name, key_rdy, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (key_rdy !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_edge104 key_rdy=%b busy=%b required key_rdy=1 busy=0", name, key_rdy, busy);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard empty queue, required one expected table", name);
        end else begin
            exp = sb.pop_front();
            if (skey_out !== exp) begin
                errors++;
                for (int n = 0; n < 26; n++)
                    if (skey_out[32*n +: 32] !== exp[32*n +: 32]) begin
                        $display("FAIL %s_table S[%0d]=%h required %h", name, n,
                                 skey_out[32*n +: 32], exp[32*n +: 32]);
                        break;
                    end
            end
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (busy !== 1'b0 || key_rdy !== 1'b0 || skey_out !== '0) begin
            errors++;
            $display("FAIL reset_initial busy=%b key_rdy=%b skey_nonzero=%b required 0 0 0",
                     busy, key_rdy, |skey_out);
        end
        @(negedge clk) clr = 1'b1;
        @(posedge clk); #1;
        accept_key({$urandom, $urandom, $urandom, $urandom});
        repeat (40) @(posedge clk);
        #2 clr = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (busy !== 1'b0 || key_rdy !== 1'b0 || skey_out !== '0) begin
            errors++;
            $display("FAIL reset_async busy=%b key_rdy=%b skey_nonzero=%b required 0 0 0",
                     busy, key_rdy, |skey_out);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || key_rdy !== 1'b0 || skey_out !== '0) begin
            errors++;
            $display("FAIL reset_held busy=%b key_rdy=%b skey_nonzero=%b required 0 0 0",
                     busy, key_rdy, |skey_out);
        end
        @(negedge clk) clr = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_key();
        logic [63:0] ct;
        accept_key('0);
        wait_done(0, "zero_key");
        ct = encrypt(skey_out);
        checks++;
        if (ct !== {32'hEEDBA521, 32'h6D8F4B15}) begin
            errors++;
            $display("FAIL zero_key_cipher A_B=%h required eedba5216d8f4b15", ct);
        end
    endtask

    task automatic test_seq_key();
        accept_key(128'h000102030405060708090A0B0C0D0E0F);
        checks++;
        if (dut.lWords[0] !== 32'h03020100) begin
            errors++;
            $display("FAIL seq_key_L0 L[0]=%h required 03020100", dut.lWords[0]);
        end
        wait_done(0, "seq_key");
    endtask

    task automatic test_ignore_busy();
        accept_key(128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
        repeat (49) @(posedge clk);
        key_in  = 128'h11111111_22222222_33333333_44444444;
        key_vld = 1'b1;
        @(posedge clk); #1;
        key_vld = 1'b0;
        checks++;
        if (busy !== 1'b1 || key_rdy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_busy_state busy=%b key_rdy=%b required 1 0", busy, key_rdy);
        end
        wait_done(50, "ignore_busy");
    endtask

    task automatic test_abort_restart();
        accept_key(128'h0F0E0D0C_0B0A0908_07060504_03020100);
        repeat (60) @(posedge clk);
        #2 clr = 1'b0;
        sb.delete();
        @(negedge clk) clr = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || key_rdy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle busy=%b key_rdy=%b required 0 0", busy, key_rdy);
        end
        accept_key(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        wait_done(0, "abort_restart");
    endtask

    task automatic test_back_to_back();
        logic [127:0] k;
        logic [831:0] tmp;
        int r;
        k = {$urandom, $urandom, $urandom, $urandom};
        for (int t = 0; t < 40; t++) begin
            tmp = model(k, r);
            if (r > 0) break;
            k = {$urandom, $urandom, $urandom, $urandom};
        end
        $display("back_to_back key=%h rotate_by_zero_steps=%0d", k, r);
        accept_key(k);
        checks++;
        if (key_rdy !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept key_rdy=%b busy=%b required 0 1", key_rdy, busy);
        end
        wait_done(0, "back_to_back");
        checks++;
        if ($isunknown(skey_out)) begin
            errors++;
            $display("FAIL b2b_xcheck skey_out has X/Z bits, required none");
        end
    endtask

    initial begin
        test_reset();
        test_zero_key();
        test_seq_key();
        test_ignore_busy();
        test_abort_restart();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
